// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Sequences an external 8-bit ALU for one request at a time. A request
//   (op, a, b, use_carry, count) is taken over a valid/ready handshake. The
//   op is then run count+1 times, with each result fed back as inA. The
//   final result and flags are returned over a second valid/ready handshake.
//   A persistent carry flag is kept across requests.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
//   high. The request side is ready only in IDLE. While the response is
//   valid (DONE), rsp_data and the rsp flags hold stable until rsp_ready is
//   seen. req_valid while busy is ignored, and so is rsp_ready while no
//   response is valid.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_op, req_a, req_b        opcode and operands
//   req_use_carry               feed carry_flag into alu_ci on every iteration
//   req_count                   extra iterations (total = req_count+1)
//   rsp_valid/rsp_ready         response handshake
//   rsp_data                    result of the final iteration
//   rsp_carry/zero/eq/gt/lt     flags from the final iteration (rsp_carry = carry_flag)
//   carry_flag                  persistent carry register
//   alu_stage                   FSM state (IDLE=00, EXEC=01, DONE=10); doubles as state debug
//   alu_op/alu_a/alu_b/alu_ci   drive to the ALU
//   alu_out                     ALU result, latched by the ALU on negedge
//   alu_co/equal/gt/lt/zero     ALU combinational flags
module alu_op_sequencer #(
  parameter int DW    = 8,
  parameter int OP_W  = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [DW-1:0]    req_a,
  input  logic [DW-1:0]    req_b,
  input  logic             req_use_carry,
  input  logic [CNT_W-1:0] req_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_eq,
  output logic             rsp_gt,
  output logic             rsp_lt,
  output logic             carry_flag,
  output logic [1:0]       alu_stage,
  output logic [OP_W-1:0]  alu_op,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic             alu_ci,
  input  logic [DW-1:0]    alu_out,
  input  logic             alu_co,
  input  logic             alu_equal,
  input  logic             alu_gt,
  input  logic             alu_lt,
  input  logic             alu_zero
);

  // Encoding 2'b11 is never assigned; it falls into the default branch.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic             use_carry_q, use_carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [DW-1:0]    res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  // Ops whose ALU carry-out updates the persistent carry register.
  function automatic logic is_carry_op(input logic [OP_W-1:0] op);
    case (op)
      5'b00111, 5'b10110, 5'b10111, 5'b10001,
      5'b10011, 5'b10010, 5'b10100, 5'b11000: is_carry_op = 1'b1;
      default:                                is_carry_op = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    use_carry_d = use_carry_q;
    count_d     = count_q;
    iter_cnt_d  = iter_cnt_q;
    res_d       = res_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ci      = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d        = req_op;
          a_d         = req_a;
          b_d         = req_b;
          use_carry_d = req_use_carry;
          count_d     = req_count;
          iter_cnt_d  = '0;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = op_q;
        // First iteration uses the request operand, later ones chain the result.
        alu_a  = (iter_cnt_q == '0) ? a_q : res_q;
        alu_b  = b_q;
        alu_ci = use_carry_q & carry_q;
        // alu_out was latched by the ALU at this cycle's negedge.
        res_d  = alu_out;
        zero_d = alu_zero;
        eq_d   = alu_equal;
        gt_d   = alu_gt;
        lt_d   = alu_lt;
        if (is_carry_op(op_q)) carry_d = alu_co;
        if (iter_cnt_q == count_q) begin
          state_d = S_DONE;
        end else begin
          iter_cnt_d = iter_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      use_carry_q <= 1'b0;
      count_q     <= '0;
      iter_cnt_q  <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      use_carry_q <= use_carry_d;
      count_q     <= count_d;
      iter_cnt_q  <= iter_cnt_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
    end
  end

  assign alu_stage  = state_q;
  assign carry_flag = carry_q;
  assign rsp_data   = res_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;
  assign rsp_eq     = eq_q;
  assign rsp_gt     = gt_q;
  assign rsp_lt     = lt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. Contains a behavioural 8-bit ALU (registered
// result on negedge, combinational flags) and a reference model that runs
// each request as a plain loop over count+1 ALU evaluations.
module tb_alu_op_sequencer;
  localparam int DW = 8, OP_W = 5, CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             req_valid = 1'b0, req_ready;
  logic [OP_W-1:0]  req_op = '0;
  logic [DW-1:0]    req_a = '0, req_b = '0;
  logic             req_use_carry = 1'b0;
  logic [CNT_W-1:0] req_count = '0;
  logic             rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0]    rsp_data;
  logic             rsp_carry, rsp_zero, rsp_eq, rsp_gt, rsp_lt, carry_flag;
  logic [1:0]       alu_stage;
  logic [OP_W-1:0]  alu_op;
  logic [DW-1:0]    alu_a, alu_b;
  logic             alu_ci;
  logic [DW-1:0]    alu_out = '0;
  logic             alu_co, alu_equal, alu_gt, alu_lt, alu_zero;
  logic [DW-1:0]    alu_comb;

  alu_op_sequencer #(.DW(DW), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_use_carry(req_use_carry), .req_count(req_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
    .carry_flag(carry_flag), .alu_stage(alu_stage), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_co(alu_co), .alu_equal(alu_equal),
    .alu_gt(alu_gt), .alu_lt(alu_lt), .alu_zero(alu_zero)
  );

  // ---------------- behavioural ALU ----------------
  // Returns {co, zero, eq, gt, lt, out}. Unknown ops give all zeros.
  function automatic logic [12:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic ci);
    logic [8:0] w;
    logic [7:0] o;
    logic co, gt, lt;
    w = '0; o = '0; co = 1'b0; gt = (a > b); lt = (a < b);
    case (op)
      5'b00111, 5'b10111: begin w = {1'b0, a} + {1'b0, b} + {8'b0, ci}; o = w[7:0]; co = w[8]; end
      5'b10110: begin w = {1'b0, a} - {1'b0, b} - {8'b0, ci}; o = w[7:0]; co = w[8]; end
      5'b00010: begin o = a - 8'd1; co = (a == 8'd0); end
      5'b01000: o = a ^ b;
      5'b10011: begin o = {a[6:0], 1'b0}; co = a[7]; end
      5'b10001: begin o = {1'b0, a[7:1]}; co = a[0]; end
      5'b10010: begin o = {a[6:0], ci}; co = a[7]; end
      5'b10100: begin o = {ci, a[7:1]}; co = a[0]; end
      5'b11000: begin o = {a[7], a[7:1]}; co = a[0]; end
      5'b00101: begin o = a - b; gt = ($signed(a) > $signed(b)); lt = ($signed(a) < $signed(b)); end
      5'b11011: o = a - b;
      default: return 13'b0;
    endcase
    return {co, (o == 8'd0), (a == b), gt, lt, o};
  endfunction

  assign {alu_co, alu_zero, alu_equal, alu_gt, alu_lt, alu_comb} = alu_fn(alu_op, alu_a, alu_b, alu_ci);
  always @(negedge clk) alu_out <= alu_comb;

  // ---------------- reference model / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic model_carry = 1'b0;
  logic [DW-1:0] exp_q[$];

  function automatic logic writes_carry(input logic [4:0] op);
    return op inside {5'b00111, 5'b10110, 5'b10111, 5'b10001, 5'b10011, 5'b10010, 5'b10100, 5'b11000};
  endfunction

  // ---------------- driver: one full request/response ----------------
  task automatic run_op(input string name, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic uc, input logic [2:0] cnt, input int hold, output int acc_cyc);
    logic [12:0] r;
    logic [7:0] x, exp_d, held;
    int n;
    // reference: count+1 evaluations, result chained into operand A
    x = a; r = '0;
    for (int i = 0; i <= int'(cnt); i++) begin
      r = alu_fn(op, x, b, uc & model_carry);
      x = r[7:0];
      if (writes_carry(op)) model_carry = r[12];
    end
    exp_q.push_back(x);
    acc_cyc = -1;

    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!req_ready) begin
      errors++; $display("FAIL %s req_ready_timeout: got 0 required 1", name);
      exp_q.delete(); return;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_carry = uc; req_count = cnt;
    @(posedge clk); acc_cyc = cyc + 1; #1;
    req_valid = 1'b0;
    checks++;
    if (alu_stage !== 2'b01 || req_ready !== 1'b0) begin
      errors++; $display("FAIL %s exec_entry: got stage=%b ready=%b required stage=01 ready=0", name, alu_stage, req_ready);
    end

    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!rsp_valid) begin
      errors++; $display("FAIL %s rsp_timeout: got no rsp_valid required one", name);
      exp_q.delete(); return;
    end
    if (n != int'(cnt) + 1) begin
      errors++; $display("FAIL %s latency: got %0d required %0d cycles", name, n, int'(cnt) + 1);
    end
    exp_d = exp_q.pop_front();
    checks++;
    if (rsp_data !== exp_d) begin
      errors++; $display("FAIL %s data: got %h required %h", name, rsp_data, exp_d);
    end
    checks++;
    if ({rsp_carry, rsp_zero, rsp_eq, rsp_gt, rsp_lt} !== {model_carry, r[11:8]}) begin
      errors++; $display("FAIL %s flags(c,z,eq,gt,lt): got %b required %b", name,
                         {rsp_carry, rsp_zero, rsp_eq, rsp_gt, rsp_lt}, {model_carry, r[11:8]});
    end
    checks++;
    if (carry_flag !== model_carry) begin
      errors++; $display("FAIL %s carry_flag: got %b required %b", name, carry_flag, model_carry);
    end

    // back-pressure: response must hold, competing request must be ignored
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_op = 5'($urandom_range(0, 31)); req_a = 8'($urandom); req_b = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0 || alu_stage !== 2'b10) begin
        errors++; $display("FAIL %s hold: got valid=%b data=%h ready=%b stage=%b required 1 %h 0 10",
                           name, rsp_valid, rsp_data, req_ready, alu_stage, held);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_stage !== 2'b00) begin
      errors++; $display("FAIL %s release: got valid=%b ready=%b stage=%b required 0 1 00", name, rsp_valid, req_ready, alu_stage);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if ({alu_stage, rsp_valid, carry_flag, rsp_data, rsp_carry, rsp_zero, rsp_eq, rsp_gt, rsp_lt} !== 16'b0 ||
        {alu_op, alu_a, alu_b, alu_ci} !== 22'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: got stage=%b rv=%b cf=%b data=%h alu_a=%h alu_op=%b ready=%b required all 0 ready=1",
                         alu_stage, rsp_valid, carry_flag, rsp_data, alu_a, alu_op, req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_carry = 1'b0;
  endtask

  task automatic test_carry_chain();
    int acc;
    run_op("add_f0_20", 5'b00111, 8'hF0, 8'h20, 1'b0, 3'd0, 0, acc);
    run_op("adc_01_01", 5'b00111, 8'h01, 8'h01, 1'b1, 3'd0, 0, acc);
    run_op("xor_5a", 5'b01000, 8'h5A, 8'h5A, 1'b0, 3'd0, 0, acc);
  endtask

  task automatic test_repeat();
    int acc;
    run_op("lsl_x3", 5'b10011, 8'h81, 8'h00, 1'b0, 3'd2, 0, acc);
    run_op("dec_x8", 5'b00010, 8'h05, 8'h00, 1'b0, 3'd7, 0, acc);
  endtask

  task automatic test_compare();
    int acc;
    run_op("scmp_80_01", 5'b00101, 8'h80, 8'h01, 1'b0, 3'd0, 0, acc);
    run_op("ucmp_80_01", 5'b11011, 8'h80, 8'h01, 1'b0, 3'd0, 0, acc);
    run_op("ucmp_eq", 5'b11011, 8'h33, 8'h33, 1'b0, 3'd0, 0, acc);
  endtask

  task automatic test_unknown_op();
    int acc;
    run_op("set_carry", 5'b00111, 8'hFF, 8'h01, 1'b0, 3'd0, 0, acc);
    run_op("unknown_op", 5'b11111, 8'h12, 8'h12, 1'b1, 3'd1, 0, acc);
  endtask

  task automatic test_hold();
    int acc;
    run_op("hold3", 5'b10111, 8'h7F, 8'h01, 1'b1, 3'd1, 3, acc);
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    run_op("b2b_first", 5'b10001, 8'hA5, 8'h00, 1'b0, 3'd3, 0, acc1);
    run_op("b2b_second", 5'b10110, 8'h10, 8'h20, 1'b1, 3'd0, 0, acc2);
    checks++;
    if (acc2 - acc1 != 3 + 3) begin
      errors++; $display("FAIL b2b_throughput: got %0d required %0d cycles between accepts", acc2 - acc1, 6);
    end
  endtask

  task automatic test_reset_mid_exec();
    int acc, seen;
    run_op("pre_carry", 5'b00111, 8'hF0, 8'h20, 1'b0, 3'd0, 0, acc);
    req_valid = 1'b1; req_op = 5'b00010; req_a = 8'h40; req_b = 8'h00; req_use_carry = 1'b0; req_count = 3'd4;
    @(posedge clk); #1;              // accepted, first iteration running
    req_valid = 1'b0;
    @(posedge clk); #1;              // second iteration running
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_carry = 1'b0;
    checks++;
    if (alu_stage !== 2'b00 || carry_flag !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_exec: got stage=%b cf=%b rv=%b ready=%b required 00 0 0 1",
                         alu_stage, carry_flag, rsp_valid, req_ready);
    end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_no_rsp: got %0d valid cycles required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [4:0] ops[14] = '{5'b00111, 5'b10111, 5'b10110, 5'b00010, 5'b01000, 5'b10011, 5'b10001,
                            5'b10010, 5'b10100, 5'b11000, 5'b00101, 5'b11011, 5'b11111, 5'b01110};
    int acc;
    for (int t = 0; t < 40; t++) begin
      run_op($sformatf("rand%0d", t), ops[$urandom_range(0, 13)], 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 2), acc);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_carry_chain();
    test_repeat();
    test_compare();
    test_unknown_op();
    test_hold();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end
endmodule
